// File: rtl/apa102_frame_rx.sv
// APA102 SPI frame receiver: synchronises sck/sda, hunts a 32-bit zero start frame, captures
// LED_CNT frames into a shadow buffer and commits them atomically. Optional macro: APA102_BRIGHTNESS_EN.
module apa102_frame_rx #(
    parameter int LED_CNT = 7,
    parameter int TIMEOUT = 4096
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   sck,
    input  logic                   sda,
    output logic [LED_CNT*32-1:0]  data_out,
    output logic                   frame_valid,
    output logic                   hdr_err,
    output logic                   busy
);
    // state    | meaning
    // HUNT     | counting consecutive zero bits looking for a start frame
    // WAIT_HDR | start frame seen, skipping extra zeros until the first frame MSB
    // DATA     | shifting LED frames into the shadow buffer
    typedef enum logic [1:0] {HUNT, WAIT_HDR, DATA} state_t;

    localparam int IDX_W = (LED_CNT > 1) ? $clog2(LED_CNT) : 1;
    localparam int TC_W  = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TC_W-1:0]  TC_LOAD  = TC_W'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LED_CNT - 1);

    logic r_sck_meta, r_sck_sync, r_sck_prev;
    logic r_sda_meta, r_sda_sync;

    state_t                      r_state;
    logic [5:0]                  r_zcnt;
    logic [4:0]                  r_bit_cnt;
    logic [IDX_W-1:0]            r_led_idx;
    logic [TC_W-1:0]             r_tcnt;
    logic [31:0]                 r_word;
    logic [LED_CNT-1:0][31:0]    r_shadow;
    logic [LED_CNT*32-1:0]       r_data_out;
    logic                        r_frame_valid;
    logic                        r_hdr_err;
    logic                        r_busy;

    logic        w_strobe;
    logic [31:0] w_word_next;
    logic [31:0] w_word_store;

    assign w_strobe    = r_sck_sync & ~r_sck_prev;
    assign w_word_next = {r_word[30:0], r_sda_sync};

`ifdef APA102_BRIGHTNESS_EN
    logic [5:0]  w_gain;
    logic [13:0] w_prod_b, w_prod_g, w_prod_r;

    assign w_gain   = {1'b0, w_word_next[28:24]} + 6'd1;
    assign w_prod_b = {6'b0, w_word_next[23:16]} * {8'b0, w_gain};
    assign w_prod_g = {6'b0, w_word_next[15:8]}  * {8'b0, w_gain};
    assign w_prod_r = {6'b0, w_word_next[7:0]}   * {8'b0, w_gain};
    // gain is 1..32, so >>5 of an 8-bit colour never exceeds 8 bits
    assign w_word_store = {w_word_next[31:24], 8'(w_prod_b >> 5), 8'(w_prod_g >> 5), 8'(w_prod_r >> 5)};
`else
    assign w_word_store = w_word_next;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sck_meta <= 1'b0;
            r_sck_sync <= 1'b0;
            r_sck_prev <= 1'b0;
            r_sda_meta <= 1'b0;
            r_sda_sync <= 1'b0;
        end else begin
            r_sck_meta <= sck;
            r_sck_sync <= r_sck_meta;
            r_sck_prev <= r_sck_sync;
            r_sda_meta <= sda;
            r_sda_sync <= r_sda_meta;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= HUNT;
            r_zcnt        <= '0;
            r_bit_cnt     <= '0;
            r_led_idx     <= '0;
            r_tcnt        <= '0;
            r_word        <= '0;
            r_shadow      <= '0;
            r_data_out    <= '0;
            r_frame_valid <= 1'b0;
            r_hdr_err     <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_frame_valid <= 1'b0;
            r_hdr_err     <= 1'b0;
            case (r_state)
                HUNT: begin
                    if (w_strobe) begin
                        if (r_sda_sync) begin
                            r_zcnt <= '0;
                        end else begin
                            r_zcnt <= (r_zcnt == 6'd32) ? r_zcnt : r_zcnt + 6'd1;
                            if (r_zcnt == 6'd31) begin
                                r_state <= WAIT_HDR;
                                r_busy  <= 1'b1;
                                r_tcnt  <= TC_LOAD;
                            end
                        end
                    end
                end
                WAIT_HDR: begin
                    if (w_strobe) begin
                        r_tcnt <= TC_LOAD;
                        if (r_sda_sync) begin
                            r_state   <= DATA;
                            r_word    <= 32'd1;
                            r_bit_cnt <= 5'd1;
                            r_led_idx <= '0;
                        end
                    end else if (r_tcnt == '0) begin
                        r_state  <= HUNT;
                        r_busy   <= 1'b0;
                        r_zcnt   <= '0;
                        r_shadow <= '0;
                    end else begin
                        r_tcnt <= r_tcnt - TC_W'(1);
                    end
                end
                DATA: begin
                    if (w_strobe) begin
                        r_tcnt <= TC_LOAD;
                        r_word <= w_word_next;
                        if (r_bit_cnt == 5'd31) begin
                            if (w_word_next[31:29] != 3'b111) begin
                                r_hdr_err <= 1'b1;
                                r_shadow  <= '0;
                                r_zcnt    <= '0;
                                r_state   <= HUNT;
                                r_busy    <= 1'b0;
                            end else begin
                                r_shadow[r_led_idx] <= w_word_store;
                                if (r_led_idx == LAST_IDX) begin
                                    // LED0 lands in the most significant word
                                    for (int i = 0; i < LED_CNT - 1; i++)
                                        r_data_out[(LED_CNT-1-i)*32 +: 32] <= r_shadow[i];
                                    r_data_out[31:0] <= w_word_store;
                                    r_frame_valid    <= 1'b1;
                                    r_zcnt           <= '0;
                                    r_state          <= HUNT;
                                    r_busy           <= 1'b0;
                                end else begin
                                    r_led_idx <= r_led_idx + IDX_W'(1);
                                    r_bit_cnt <= '0;
                                end
                            end
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 5'd1;
                        end
                    end else if (r_tcnt == '0) begin
                        r_state  <= HUNT;
                        r_busy   <= 1'b0;
                        r_zcnt   <= '0;
                        r_shadow <= '0;
                    end else begin
                        r_tcnt <= r_tcnt - TC_W'(1);
                    end
                end
                default: begin
                    r_state <= HUNT;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign data_out    = r_data_out;
    assign frame_valid = r_frame_valid;
    assign hdr_err     = r_hdr_err;
    assign busy        = r_busy;
endmodule

// File: tb/tb_apa102_frame_rx.sv
// Directed + randomised bench for apa102_frame_rx; reference model derives committed data from frame lists.
module tb_apa102_frame_rx;
    localparam int LED_CNT = 7;
    localparam int TIMEOUT = 4096;
    localparam int W = LED_CNT * 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         sck;
    logic         sda;
    logic [W-1:0] data_out;
    logic         frame_valid;
    logic         hdr_err;
    logic         busy;

    int total = 0;
    int bad = 0;
    int n_fv = 0;
    int n_he = 0;
    int n_both = 0;

    logic [31:0]  frames [LED_CNT];
    logic [W-1:0] exp_data;

    always #5 clk = ~clk;

    apa102_frame_rx #(.LED_CNT(LED_CNT), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .sck(sck), .sda(sda),
        .data_out(data_out), .frame_valid(frame_valid), .hdr_err(hdr_err), .busy(busy)
    );

    always @(negedge clk) begin
        if (frame_valid) n_fv++;
        if (hdr_err) n_he++;
        if (frame_valid && hdr_err) n_both++;
    end

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // brightness: each colour byte becomes floor(c * (gb+1) / 32)
    function automatic logic [31:0] model_word(input logic [31:0] w);
`ifdef APA102_BRIGHTNESS_EN
        int g;
        int c;
        logic [31:0] r;
        g = int'(w[28:24]) + 1;
        r = w;
        for (int k = 0; k < 3; k++) begin
            c = int'(w[k*8 +: 8]);
            r[k*8 +: 8] = 8'((c * g) / 32);
        end
        return r;
`else
        return w;
`endif
    endfunction

    function automatic logic [W-1:0] model_out();
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < LED_CNT; i++) r[(LED_CNT-1-i)*32 +: 32] = model_word(frames[i]);
        return r;
    endfunction

    function automatic bit model_ok();
        for (int i = 0; i < LED_CNT; i++) if (frames[i][31:29] != 3'b111) return 1'b0;
        return 1'b1;
    endfunction

    task automatic send_bit(input logic b);
        sda = b;
        repeat (4) @(negedge clk);
        sck = 1'b1;
        repeat (4) @(negedge clk);
        sck = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 31; i >= 0; i--) send_bit(w[i]);
    endtask

    task automatic send_const(input int n, input logic b);
        for (int i = 0; i < n; i++) send_bit(b);
    endtask

    task automatic do_update(input string tag, input int nz);
        int fv0;
        int he0;
        bit ok;
        fv0 = n_fv;
        he0 = n_he;
        send_const(nz, 1'b0);
        for (int i = 0; i < LED_CNT; i++) send_word(frames[i]);
        send_const(32, 1'b1);
        repeat (10) @(negedge clk);
        ok = model_ok();
        if (ok) exp_data = model_out();
        check({tag, " data"}, data_out, exp_data);
        check({tag, " fv"}, W'(n_fv - fv0), W'(ok ? 1 : 0));
        check({tag, " he"}, W'(n_he - he0), W'(ok ? 0 : 1));
        check({tag, " busy"}, W'(busy), '0);
    endtask

    task automatic fill_pattern();
        for (int n = 0; n < LED_CNT; n++)
            frames[n] = {8'hFF, 4'(n), 4'h0, 4'(n), 4'h1, 4'(n), 4'h2};
    endtask

    task automatic fill_random(input bit allow_bad);
        int bad_idx;
        logic [2:0] bad_hdr;
        for (int n = 0; n < LED_CNT; n++)
            frames[n] = {3'b111, 5'($urandom_range(0, 31)), 24'($urandom)};
        if (allow_bad && $urandom_range(0, 2) == 0) begin
            bad_idx = $urandom_range(0, LED_CNT - 1);
            case ($urandom_range(0, 2))
                0: bad_hdr = 3'b110;
                1: bad_hdr = 3'b101;
                default: bad_hdr = 3'b011;
            endcase
            frames[bad_idx][31:29] = bad_hdr;
        end
    endtask

    initial begin
        int fv0;
        int he0;
        logic [W-1:0] held;
        reset = 1'b1;
        sck = 1'b0;
        sda = 1'b0;
        exp_data = '0;
        repeat (5) @(negedge clk);
        check("rst data", data_out, '0);
        check("rst fv", W'(frame_valid), '0);
        check("rst he", W'(hdr_err), '0);
        check("rst busy", W'(busy), '0);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        // full update with the n0/n1/n2 pattern
        fill_pattern();
        do_update("t2", 32);

        // reset after two frames of a capture
        fill_random(1'b0);
        send_const(32, 1'b0);
        send_word(frames[0]);
        send_word(frames[1]);
        check("t1 busy mid", W'(busy), W'(1));
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("t1 data", data_out, '0);
        check("t1 busy", W'(busy), '0);
        check("t1 fv", W'(frame_valid), '0);
        check("t1 he", W'(hdr_err), '0);
        reset = 1'b0;
        exp_data = '0;
        repeat (3) @(negedge clk);
        fill_random(1'b0);
        do_update("t1 after", 32);

        // bad header on LED3, then a good update
        fill_pattern();
        frames[3][31:24] = 8'h7F;
        do_update("t3 bad", 32);
        fill_pattern();
        do_update("t3 good", 32);

        // sck stalls after four frames
        fill_random(1'b0);
        held = data_out;
        fv0 = n_fv;
        he0 = n_he;
        send_const(32, 1'b0);
        for (int i = 0; i < 4; i++) send_word(frames[i]);
        check("t4 busy start", W'(busy), W'(1));
        repeat (4085) @(negedge clk);
        check("t4 busy pre", W'(busy), W'(1));
        repeat (20) @(negedge clk);
        check("t4 busy post", W'(busy), '0);
        repeat (5000 - 4105) @(negedge clk);
        check("t4 data held", data_out, held);
        check("t4 no pulse", W'((n_fv - fv0) + (n_he - he0)), '0);
        fill_random(1'b0);
        do_update("t4 resume", 32);

        // 31-zero start frame must not sync
        fill_pattern();
        held = data_out;
        fv0 = n_fv;
        send_const(31, 1'b0);
        send_bit(1'b1);
        for (int i = 0; i < LED_CNT; i++) send_word(frames[i]);
        send_const(32, 1'b1);
        repeat (10) @(negedge clk);
        check("t5 data held", data_out, held);
        check("t5 no fv", W'(n_fv - fv0), '0);
        check("t5 busy", W'(busy), '0);
        do_update("t5 long start", 40);

        // brightness field: gb=15 halves (rounded down), gb=31 is identity
        for (int i = 0; i < LED_CNT; i++) frames[i] = 32'hEFFFFFFF;
        do_update("t6 gb15", 32);
`ifdef APA102_BRIGHTNESS_EN
        check("t6 gb15 word", W'(data_out[31:0]), W'(32'hEF7F7F7F));
`else
        check("t6 gb15 word", W'(data_out[31:0]), W'(32'hEFFFFFFF));
`endif
        for (int i = 0; i < LED_CNT; i++) frames[i] = 32'hFFA5C33C ^ 32'(i);
        do_update("t6 gb31", 32);
        check("t6 gb31 word", W'(data_out[31:0]), W'(32'hFFA5C33A));

        // random updates, some carrying one bad header
        for (int r = 0; r < 6; r++) begin
            fill_random(1'b1);
            do_update($sformatf("rand%0d", r), 32 + $urandom_range(0, 8));
        end

        check("never both pulses", W'(n_both), '0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
